gci_irq_arbiter: RTL and testbench

GCI_IRQ_ARBITER -- requirements
Module: gci_irq_arbiter

---
 rtl/gci_irq_pkg.sv | 27 ++
 rtl/gci_irq_prio_sel.sv | 40 ++++
 rtl/gci_irq_arbiter.sv | 114 +++++++++++
 tb/tb_gci_irq_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gci_irq_pkg.sv
// Shared GCI IRQ definitions: arbiter state encodings, priority width and
// small helpers used by the arbiter and the other GCI blocks.
package gci_irq_pkg;

  localparam int IRQ_PRIO_W   = 8;
  localparam int IRQ_NODE_NUM = 4;

  typedef enum logic [1:0] {
    IRQ_ARB_IDLE       = 2'd0,
    IRQ_ARB_REQ        = 2'd1,
    IRQ_ARB_CLEAR_WAIT = 2'd2
  } irq_arb_state_e;

  // One-hot decode of a node index.
  function automatic logic [IRQ_NODE_NUM-1:0] irq_onehot(input logic [1:0] idx);
    irq_onehot = 4'b0001 << idx;
  endfunction

  // Extract the 8-bit priority of node idx from the packed priority bus.
  function automatic logic [IRQ_PRIO_W-1:0] irq_prio_of(
    input logic [IRQ_NODE_NUM*IRQ_PRIO_W-1:0] prios,
    input logic [1:0]                          idx
  );
    irq_prio_of = prios[{idx, 3'b000} +: IRQ_PRIO_W];
  endfunction

endpackage

// File: rtl/gci_irq_prio_sel.sv
// Combinational winner selection: highest priority among eligible nodes,
// ties resolved round-robin starting one past the last granted node.
module gci_irq_prio_sel
  import gci_irq_pkg::*;
(
  input  logic [IRQ_NODE_NUM-1:0]            eligible,
  input  logic [IRQ_NODE_NUM*IRQ_PRIO_W-1:0] priorities,
  input  logic [1:0]                         last_grant,
  output logic                               valid,
  output logic [1:0]                         grant
);

  logic [1:0]            idx_s;
  logic [IRQ_PRIO_W-1:0] best_prio_s;
  logic [1:0]            best_idx_s;
  logic                  found_s;

  // Scan nodes in round-robin order; only a strictly higher priority replaces
  // the current best, so the first node in scan order wins a tie.
  always_comb begin
    idx_s       = last_grant + 2'd1;
    best_prio_s = {IRQ_PRIO_W{1'b0}};
    best_idx_s  = 2'd0;
    found_s     = 1'b0;
    for (int i = 0; i < IRQ_NODE_NUM; i++) begin
      if (eligible[idx_s] && (!found_s || (irq_prio_of(priorities, idx_s) > best_prio_s))) begin
        found_s     = 1'b1;
        best_prio_s = irq_prio_of(priorities, idx_s);
        best_idx_s  = idx_s;
      end else begin
        found_s     = found_s;
      end
      idx_s = idx_s + 2'd1;
    end
  end

  assign valid = found_s;
  assign grant = best_idx_s;

endmodule

// File: rtl/gci_irq_arbiter.sv
// GCI node IRQ arbiter: picks one eligible node, presents it to the CPU,
// forwards the CPU acknowledge to the node and waits for its request to clear.
module gci_irq_arbiter
  import gci_irq_pkg::*;
#(
  parameter int NODE_NUM = 4
)(
  input  logic                           iCLOCK,
  input  logic                           iRESET_SYNC,
  input  logic [NODE_NUM-1:0]            iNODE_VALID,
  input  logic [NODE_NUM-1:0]            iNODEINFO_VALID,
  input  logic [NODE_NUM*IRQ_PRIO_W-1:0] iNODEINFO_PRIORITY,
  input  logic [NODE_NUM-1:0]            iNODE_IRQ_REQ,
  output logic [NODE_NUM-1:0]            oNODE_IRQ_ACK,
  output logic [NODE_NUM-1:0]            oNODE_IRQ_BUSY,
  input  logic [NODE_NUM-1:0]            iIRQ_MASK,
  output logic                           oCPU_IRQ_REQ,
  output logic [1:0]                     oCPU_IRQ_NUM,
  input  logic                           iCPU_IRQ_ACK,
  input  logic                           iCPU_IRQ_BUSY
);

  irq_arb_state_e      state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          last_grant_q, last_grant_d;
  logic [NODE_NUM-1:0] ack_q, ack_d;

  logic [NODE_NUM-1:0] eligible_s;
  logic                sel_valid_s;
  logic [1:0]          sel_grant_s;
  logic [NODE_NUM-1:0] busy_s;

  assign eligible_s = iNODE_VALID & iNODEINFO_VALID & iNODE_IRQ_REQ & ~iIRQ_MASK;

  gci_irq_prio_sel u_prio_sel (
    .eligible   (eligible_s),
    .priorities (iNODEINFO_PRIORITY),
    .last_grant (last_grant_q),
    .valid      (sel_valid_s),
    .grant      (sel_grant_s)
  );

  // Next-state logic: arbitrate only in IDLE, hold the grant through REQ,
  // and drop a grant whose device disappears before the CPU acknowledges.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack_d        = {NODE_NUM{1'b0}};
    case (state_q)
      IRQ_ARB_IDLE: begin
        if (!iCPU_IRQ_BUSY && sel_valid_s) begin
          state_d = IRQ_ARB_REQ;
          grant_d = sel_grant_s;
        end else begin
          state_d = IRQ_ARB_IDLE;
        end
      end
      IRQ_ARB_REQ: begin
        if (!iNODE_VALID[grant_q]) begin
          state_d = IRQ_ARB_IDLE;
        end else if (iCPU_IRQ_ACK) begin
          ack_d        = irq_onehot(grant_q);
          last_grant_d = grant_q;
          state_d      = IRQ_ARB_CLEAR_WAIT;
        end else begin
          state_d = IRQ_ARB_REQ;
        end
      end
      IRQ_ARB_CLEAR_WAIT: begin
        if (!iNODE_IRQ_REQ[grant_q] || !iNODE_VALID[grant_q]) begin
          state_d = IRQ_ARB_IDLE;
        end else begin
          state_d = IRQ_ARB_CLEAR_WAIT;
        end
      end
      default: begin
        state_d = IRQ_ARB_IDLE;
      end
    endcase
  end

  // State, grant and ACK pulse registers; reset wins over everything and
  // seeds last_grant so node 0 takes the first tie.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q      <= IRQ_ARB_IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      ack_q        <= {NODE_NUM{1'b0}};
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
    end
  end

  // Hold off every node while the CPU is busy, and every non-granted node
  // while an IRQ is in flight.
  always_comb begin
    if (state_q != IRQ_ARB_IDLE) begin
      busy_s = {NODE_NUM{iCPU_IRQ_BUSY}} | ~irq_onehot(grant_q);
    end else begin
      busy_s = {NODE_NUM{iCPU_IRQ_BUSY}};
    end
  end

  assign oCPU_IRQ_REQ   = (state_q == IRQ_ARB_REQ);
  assign oCPU_IRQ_NUM   = grant_q;
  assign oNODE_IRQ_ACK  = ack_q;
  assign oNODE_IRQ_BUSY = busy_s;

endmodule

// File: tb/tb_gci_irq_arbiter.sv
// Scoreboard bench for gci_irq_arbiter: stimulus pushes expected CPU request
// and node ACK events, a negedge monitor pops and compares them.
module tb_gci_irq_arbiter;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC;
  logic [3:0]  iNODE_VALID;
  logic [3:0]  iNODEINFO_VALID;
  logic [31:0] iNODEINFO_PRIORITY;
  logic [3:0]  iNODE_IRQ_REQ;
  logic [3:0]  oNODE_IRQ_ACK;
  logic [3:0]  oNODE_IRQ_BUSY;
  logic [3:0]  iIRQ_MASK;
  logic        oCPU_IRQ_REQ;
  logic [1:0]  oCPU_IRQ_NUM;
  logic        iCPU_IRQ_ACK;
  logic        iCPU_IRQ_BUSY;

  gci_irq_arbiter #(.NODE_NUM(4)) dut (
    .iCLOCK             (iCLOCK),
    .iRESET_SYNC        (iRESET_SYNC),
    .iNODE_VALID        (iNODE_VALID),
    .iNODEINFO_VALID    (iNODEINFO_VALID),
    .iNODEINFO_PRIORITY (iNODEINFO_PRIORITY),
    .iNODE_IRQ_REQ      (iNODE_IRQ_REQ),
    .oNODE_IRQ_ACK      (oNODE_IRQ_ACK),
    .oNODE_IRQ_BUSY     (oNODE_IRQ_BUSY),
    .iIRQ_MASK          (iIRQ_MASK),
    .oCPU_IRQ_REQ       (oCPU_IRQ_REQ),
    .oCPU_IRQ_NUM       (oCPU_IRQ_NUM),
    .iCPU_IRQ_ACK       (iCPU_IRQ_ACK),
    .iCPU_IRQ_BUSY      (iCPU_IRQ_BUSY)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    bit         is_ack;
    logic [3:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  logic       prev_req = 1'b0;
  logic [1:0] prev_num = 2'd0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_req(input int n);
    ev_t e;
    e.is_ack = 1'b0;
    e.val    = 4'(n);
    exp_q.push_back(e);
  endtask

  task automatic expect_ack(input int n);
    ev_t e;
    e.is_ack = 1'b1;
    e.val    = 4'b0001 << n;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input bit is_ack, input logic [3:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual=%s:%0h required=none", is_ack ? "ack" : "req", val);
    end else begin
      e = exp_q.pop_front();
      if (e.is_ack != is_ack || e.val !== val) begin
        errors++;
        $display("FAIL event actual=%s:%0h required=%s:%0h",
                 is_ack ? "ack" : "req", val, e.is_ack ? "ack" : "req", e.val);
      end
    end
  endtask

  // Monitor: a rising CPU request or any ACK pulse is an event to score;
  // the granted number must not move while the request is held.
  always @(negedge iCLOCK) begin
    if (oCPU_IRQ_REQ && !prev_req) check_event(1'b0, {2'b00, oCPU_IRQ_NUM});
    if (oCPU_IRQ_REQ && prev_req) chk("num_stable", {6'd0, oCPU_IRQ_NUM}, {6'd0, prev_num});
    if (oNODE_IRQ_ACK != 4'b0000) check_event(1'b1, oNODE_IRQ_ACK);
    prev_req = oCPU_IRQ_REQ;
    prev_num = oCPU_IRQ_NUM;
  end

  task automatic tick;
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic set_prio(input int n, input logic [7:0] p);
    iNODEINFO_PRIORITY[8*n +: 8] = p;
  endtask

  task automatic clear_inputs;
    iNODE_VALID        = 4'hF;
    iNODEINFO_VALID    = 4'hF;
    iNODEINFO_PRIORITY = 32'h0;
    iNODE_IRQ_REQ      = 4'h0;
    iIRQ_MASK          = 4'h0;
    iCPU_IRQ_ACK       = 1'b0;
    iCPU_IRQ_BUSY      = 1'b0;
  endtask

  task automatic do_reset;
    iRESET_SYNC = 1'b1;
    tick;
    tick;
    iRESET_SYNC = 1'b0;
  endtask

  task automatic wait_req;
    int n;
    n = 0;
    while (!oCPU_IRQ_REQ && n < 20) begin
      tick;
      n++;
    end
    chk("req_timeout", {7'd0, oCPU_IRQ_REQ}, 8'd1);
  endtask

  // CPU side of one IRQ: wait for the request, acknowledge, then the node
  // withdraws its request so the arbiter returns to IDLE.
  task automatic serve(input int n);
    logic [3:0] oh;
    oh = 4'b0001 << n;
    wait_req;
    chk("busy_in_req", {4'd0, oNODE_IRQ_BUSY}, {4'd0, ~oh});
    iCPU_IRQ_ACK = 1'b1;
    tick;
    iCPU_IRQ_ACK = 1'b0;
    chk("ack_pulse", {4'd0, oNODE_IRQ_ACK}, {4'd0, oh});
    iNODE_IRQ_REQ[n] = 1'b0;
    tick;
    chk("ack_one_cycle", {4'd0, oNODE_IRQ_ACK}, 8'd0);
    chk("idle_busy", {4'd0, oNODE_IRQ_BUSY}, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    clear_inputs;
    iRESET_SYNC = 1'b1;
    tick;
    tick;
    iRESET_SYNC = 1'b0;

    // Reset values
    chk("rst_req", {7'd0, oCPU_IRQ_REQ}, 8'd0);
    chk("rst_num", {6'd0, oCPU_IRQ_NUM}, 8'd0);
    chk("rst_ack", {4'd0, oNODE_IRQ_ACK}, 8'd0);
    chk("rst_busy", {4'd0, oNODE_IRQ_BUSY}, 8'd0);

    // Single IRQ on node 2, one-cycle IDLE->REQ latency
    set_prio(2, 8'h10);
    expect_req(2);
    expect_ack(2);
    iNODE_IRQ_REQ[2] = 1'b1;
    tick;
    chk("single_latency", {7'd0, oCPU_IRQ_REQ}, 8'd1);
    chk("single_num", {6'd0, oCPU_IRQ_NUM}, 8'd2);
    serve(2);

    // Priority plus round-robin tie: grants 1, 3, 0
    clear_inputs;
    do_reset;
    set_prio(0, 8'h05);
    set_prio(1, 8'h20);
    set_prio(3, 8'h20);
    expect_req(1); expect_ack(1);
    expect_req(3); expect_ack(3);
    expect_req(0); expect_ack(0);
    iNODE_IRQ_REQ = 4'b1011;
    serve(1);
    serve(3);
    serve(0);

    // CPU ACK in IDLE is ignored
    clear_inputs;
    iCPU_IRQ_ACK = 1'b1;
    tick;
    iCPU_IRQ_ACK = 1'b0;
    tick;
    chk("idle_ack_ignored", {4'd0, oNODE_IRQ_ACK}, 8'd0);

    // Mask gate, then init-done gate, then release
    set_prio(1, 8'h40);
    iIRQ_MASK[1] = 1'b1;
    iNODE_IRQ_REQ[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (oCPU_IRQ_REQ) seen = 1'b1;
    end
    chk("mask_gate", {7'd0, seen}, 8'd0);
    iIRQ_MASK[1] = 1'b0;
    iNODEINFO_VALID[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (oCPU_IRQ_REQ) seen = 1'b1;
    end
    chk("info_gate", {7'd0, seen}, 8'd0);
    expect_req(1);
    expect_ack(1);
    iNODEINFO_VALID[1] = 1'b1;
    serve(1);

    // CPU busy blocks arbitration; release gives REQ one cycle later
    clear_inputs;
    iCPU_IRQ_BUSY = 1'b1;
    iNODE_IRQ_REQ[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick;
    chk("busy_no_req", {7'd0, oCPU_IRQ_REQ}, 8'd0);
    chk("busy_all", {4'd0, oNODE_IRQ_BUSY}, 8'h0F);
    expect_req(0);
    expect_ack(0);
    iCPU_IRQ_BUSY = 1'b0;
    tick;
    chk("busy_release_req", {7'd0, oCPU_IRQ_REQ}, 8'd1);
    serve(0);

    // Device removal while in REQ: no ACK, pending node 0 served next
    clear_inputs;
    set_prio(3, 8'h30);
    set_prio(0, 8'h01);
    expect_req(3);
    expect_req(0);
    expect_ack(0);
    iNODE_IRQ_REQ = 4'b1001;
    wait_req;
    chk("removal_num", {6'd0, oCPU_IRQ_NUM}, 8'd3);
    iNODE_VALID[3] = 1'b0;
    tick;
    chk("removal_idle", {7'd0, oCPU_IRQ_REQ}, 8'd0);
    chk("removal_no_ack", {4'd0, oNODE_IRQ_ACK}, 8'd0);
    serve(0);

    // Reset during CLEAR_WAIT, then a 0/2 tie grants node 0 first
    clear_inputs;
    set_prio(1, 8'h11);
    expect_req(1);
    expect_ack(1);
    iNODE_IRQ_REQ[1] = 1'b1;
    wait_req;
    iCPU_IRQ_ACK = 1'b1;
    tick;
    iCPU_IRQ_ACK = 1'b0;
    iRESET_SYNC = 1'b1;
    tick;
    chk("mid_rst_req", {7'd0, oCPU_IRQ_REQ}, 8'd0);
    chk("mid_rst_num", {6'd0, oCPU_IRQ_NUM}, 8'd0);
    chk("mid_rst_ack", {4'd0, oNODE_IRQ_ACK}, 8'd0);
    chk("mid_rst_busy", {4'd0, oNODE_IRQ_BUSY}, 8'd0);
    iRESET_SYNC = 1'b0;
    iNODE_IRQ_REQ[1] = 1'b0;
    set_prio(0, 8'h40);
    set_prio(2, 8'h40);
    expect_req(0); expect_ack(0);
    expect_req(2); expect_ack(2);
    iNODE_IRQ_REQ[0] = 1'b1;
    iNODE_IRQ_REQ[2] = 1'b1;
    serve(0);
    serve(2);

    tick;
    tick;
    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
